// File: rtl/alu_seq_if.sv
// Valid/ready bundle between the execute stage and the multi-cycle ALU.
// The master drives operands and consumes results.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALUSel;
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALU_Output;
   logic [1:0]       Offset;
   logic [WIDTH-1:0] Address;
   logic             div_by_zero;

   modport master (
      output A, B, ALUSel, in_valid, out_ready,
      input  in_ready, out_valid, ALU_Output,
      input  Offset, Address, div_by_zero
   );

   modport slave (
      input  A, B, ALUSel, in_valid, out_ready,
      output in_ready, out_valid, ALU_Output,
      output Offset, Address, div_by_zero
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle RV32 ALU with iterative multiply and divide.
// Results are registered and held until the consumer takes them.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, MUL, DIV, FIX, DONE
   } state_t;

   localparam logic [WIDTH-1:0] MINV =
      {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state;
   state_t             state_nxt;
   state_t             start_st;
   logic               accept;
   logic               is_mul;
   logic               is_div;
   logic               is_sdiv;
   logic               b_zero;
   logic               ovf;
   logic               last;
   logic [SHW-1:0]     shamt;
   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   sum_ab;
   logic [WIDTH-1:0]   one_res;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     psum;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   dvs;
   logic [WIDTH:0]     shl;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   q_fin;
   logic [WIDTH-1:0]   r_fin;
   logic [3:0]         sel_r;
   logic               neg_q;
   logic               neg_r;

   assign accept  = bus.in_valid && bus.in_ready;
   assign bus.in_ready = !rst &&
      (state == IDLE || (state == DONE && bus.out_ready));
   assign bus.out_valid = (state == DONE);

   assign sum_ab  = bus.A + bus.B;
   assign shamt   = bus.B[SHW-1:0];
   assign is_mul  = (bus.ALUSel[3:1] == 3'b101);
   assign is_div  = (bus.ALUSel[3:2] == 2'b11);
   assign is_sdiv = is_div && !bus.ALUSel[0];
   assign b_zero  = (bus.B == '0);
   assign ovf     = is_sdiv && (bus.A == MINV) && (bus.B == '1);
   assign last    = (cnt == SHW'(WIDTH-1));

   assign abs_a = (is_sdiv && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign abs_b = (is_sdiv && bus.B[WIDTH-1]) ? -bus.B : bus.B;

   // One shift-add step: add multiplicand when the low bit is set
   assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                 {1'b0, mcand & {WIDTH{prod[0]}}};

   // One restoring-divide step on the shifted partial remainder
   assign shl  = {rem, quo[WIDTH-1]};
   assign diff = shl - {1'b0, dvs};

   assign q_fin = (!sel_r[0] && neg_q) ? -quo : quo;
   assign r_fin = (!sel_r[0] && neg_r) ? -rem : rem;

   // Single-cycle results, including the divide special cases
   always_comb begin
      one_res = '0;
      case (bus.ALUSel)
         4'b0000: one_res = bus.A & bus.B;
         4'b0001: one_res = bus.A | bus.B;
         4'b0010: one_res = {{(WIDTH-1){1'b0}},
                     $signed(bus.A) < $signed(bus.B)};
         4'b0011: one_res = sum_ab;
         4'b0100: one_res = bus.A >> shamt;
         4'b0101: one_res = WIDTH'($signed(bus.A) >>> shamt);
         4'b0110: one_res = bus.A - bus.B;
         4'b0111: one_res = bus.A ^ bus.B;
         4'b1000: one_res = bus.A << shamt;
         4'b1001: one_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
         4'b1100,
         4'b1101: one_res = b_zero ? '1 : MINV;
         4'b1110,
         4'b1111: one_res = b_zero ? bus.A : '0;
         default: one_res = '0;
      endcase
   end

   // Where an accepted op goes first
   always_comb begin
      start_st = DONE;
      if (is_mul)
         start_st = MUL;
      else if (is_div && !b_zero && !ovf)
         start_st = DIV;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = start_st;
         MUL:  if (last) state_nxt = DONE;
         DIV:  if (last) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: begin
            if (accept)
               state_nxt = start_st;
            else if (bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ALU_Output  <= '0;
         bus.Address     <= '0;
         bus.Offset      <= '0;
         bus.div_by_zero <= 1'b0;
         sel_r <= '0;
         cnt   <= '0;
         mcand <= '0;
         prod  <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  bus.ALU_Output  <= one_res;
                  bus.Address     <= {sum_ab[WIDTH-1:2], 2'b00};
                  bus.Offset      <= sum_ab[1:0];
                  bus.div_by_zero <= is_div && b_zero;
                  sel_r <= bus.ALUSel;
                  cnt   <= '0;
                  mcand <= bus.A;
                  prod  <= {{WIDTH{1'b0}}, bus.B};
                  quo   <= abs_a;
                  rem   <= '0;
                  dvs   <= abs_b;
                  neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                  neg_r <= bus.A[WIDTH-1];
               end
            end
            MUL: begin
               prod <= {psum, prod[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
               if (last)
                  bus.ALU_Output <= sel_r[0] ? psum[WIDTH:1] :
                     {psum[0], prod[WIDTH-1:1]};
            end
            DIV: begin
               cnt <= cnt + 1'b1;
               if (diff[WIDTH]) begin
                  rem <= shl[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end else begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end
            end
            FIX: begin
               bus.ALU_Output <= sel_r[1] ? r_fin : q_fin;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors,
// handshake/reset sequences and random ops against a model.
module tb_alu_seq;
   localparam int W = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      logic        dbz;
   } vec_t;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] s,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      logic [31:0] r;
      int sh;
      sh = int'(b[4:0]);
      p  = {32'b0, a} * {32'b0, b};
      r  = '0;
      case (s)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:  r = a + b;
         4'd4:  r = a >> sh;
         4'd5:  r = $signed(a) >>> sh;
         4'd6:  r = a - b;
         4'd7:  r = a ^ b;
         4'd8:  r = a << sh;
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd10: r = p[31:0];
         4'd11: r = p[63:32];
         4'd12: begin
            if (b == 0) r = '1;
            else if (a == MINV && b == '1) r = MINV;
            else r = $signed(a) / $signed(b);
         end
         4'd13: r = (b == 0) ? '1 : a / b;
         4'd14: begin
            if (b == 0) r = a;
            else if (a == MINV && b == '1) r = '0;
            else r = $signed(a) % $signed(b);
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [3:0] s,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
      if (s == 4'd10 || s == 4'd11) return W + 1;
      if (s >= 4'd12) begin
         if (b == 0) return 1;
         if (!s[0] && a == MINV && b == '1) return 1;
         return W + 2;
      end
      return 1;
   endfunction

   // Issue one op from IDLE, wait for the result, then drain it.
   task automatic run_op(input string name,
                         input logic [3:0] s,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp_res,
                         input int exp_lat,
                         input logic exp_dbz);
      int lat;
      logic [31:0] sum;
      sum = a + b;
      @(negedge clk);
      bus.A = a;
      bus.B = b;
      bus.ALUSel = s;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, bus.ALU_Output, exp_res);
      check({name, " dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
      check({name, " address"}, bus.Address,
            {sum[31:2], 2'b00});
      check({name, " offset"}, 32'(bus.Offset), 32'(sum[1:0]));
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   vec_t vt[$];
   logic [31:0] hold_res;
   logic [31:0] hold_adr;

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.A = '0;
      bus.B = '0;
      bus.ALUSel = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst in_ready", 32'(bus.in_ready), 32'd0);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst result", bus.ALU_Output, 32'd0);
      check("rst address", bus.Address, 32'd0);
      check("rst offset", 32'(bus.Offset), 32'd0);
      check("rst dbz", 32'(bus.div_by_zero), 32'd0);
      rst = 1'b0;
      #1;
      check("post rst in_ready", 32'(bus.in_ready), 32'd1);

      vt.push_back('{4'h0, 32'h0000F0AF, 32'h0F0FF034,
                     32'h0000F024, 1, 1'b0});
      vt.push_back('{4'h2, 32'd5, 32'hFFFFFFFF, 32'd0, 1, 1'b0});
      vt.push_back('{4'h9, 32'd5, 32'hFFFFFFFF, 32'd1, 1, 1'b0});
      vt.push_back('{4'h5, 32'hF0000F2F, 32'd5,
                     32'hFF800079, 1, 1'b0});
      vt.push_back('{4'h4, 32'hF0000F2F, 32'd5,
                     32'h07800079, 1, 1'b0});
      vt.push_back('{4'h3, 32'hFFFFFFFF, 32'd2, 32'd1, 1, 1'b0});
      vt.push_back('{4'h6, 32'd5, 32'd7, 32'hFFFFFFFE, 1, 1'b0});
      vt.push_back('{4'h1, 32'h00F0, 32'h0F00, 32'h0FF0, 1, 1'b0});
      vt.push_back('{4'h7, 32'hFF00, 32'h0FF0, 32'hF0F0, 1, 1'b0});
      vt.push_back('{4'h8, 32'd1, 32'd63, 32'h80000000, 1, 1'b0});
      vt.push_back('{4'hA, 32'd14, 32'd3, 32'd42, 33, 1'b0});
      vt.push_back('{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 33, 1'b0});
      vt.push_back('{4'hC, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFD, 34, 1'b0});
      vt.push_back('{4'hE, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 34, 1'b0});
      vt.push_back('{4'hD, 32'd14, 32'd3, 32'd4, 34, 1'b0});
      vt.push_back('{4'hD, 32'd14, 32'd0, 32'hFFFFFFFF, 1, 1'b1});
      vt.push_back('{4'hF, 32'd14, 32'd0, 32'd14, 1, 1'b1});
      vt.push_back('{4'hE, 32'h80000000, 32'hFFFFFFFF,
                     32'd0, 1, 1'b0});
      vt.push_back('{4'hC, 32'h80000000, 32'hFFFFFFFF,
                     32'h80000000, 1, 1'b0});
      vt.push_back('{4'hC, 32'd7, 32'hFFFFFFFE,
                     32'hFFFFFFFD, 34, 1'b0});
      vt.push_back('{4'hE, 32'd7, 32'hFFFFFFFE, 32'd1, 34, 1'b0});

      foreach (vt[i])
         run_op($sformatf("vec%0d", i), vt[i].sel, vt[i].a,
                vt[i].b, vt[i].res, vt[i].lat, vt[i].dbz);

      // Back-pressure: outputs frozen while out_ready is low
      @(negedge clk);
      bus.A = 32'd100;
      bus.B = 32'd23;
      bus.ALUSel = 4'h3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.A = 32'hDEAD0000;
      bus.B = 32'h0000BEEF;
      hold_res = 32'd123;
      hold_adr = 32'd120;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("hold out_valid", 32'(bus.out_valid), 32'd1);
         check("hold in_ready", 32'(bus.in_ready), 32'd0);
         check("hold result", bus.ALU_Output, hold_res);
         check("hold address", bus.Address, hold_adr);
         check("hold offset", 32'(bus.Offset), 32'd3);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold drain", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;

      // Streaming: one ADD result per cycle
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.A = 32'(1000 * (k + 1));
         bus.B = 32'(k + 5);
         bus.ALUSel = 4'h3;
         bus.in_valid = 1'b1;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("stream%0d valid", k),
               32'(bus.out_valid), 32'd1);
         check($sformatf("stream%0d result", k), bus.ALU_Output,
               32'(1000 * (k + 1) + k + 5));
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("stream end", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;

      // Reset in the middle of a divide
      @(negedge clk);
      bus.A = 32'd100;
      bus.B = 32'd7;
      bus.ALUSel = 4'hD;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort out_valid", 32'(bus.out_valid), 32'd0);
      check("abort in_ready", 32'(bus.in_ready), 32'd0);
      check("abort result", bus.ALU_Output, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         check("abort no result", 32'(bus.out_valid), 32'd0);
      end
      run_op("after abort", 4'hD, 32'd100, 32'd7, 32'd14,
             34, 1'b0);

      // Random ops against the behavioural model
      for (int n = 0; n < 200; n++) begin
         logic [3:0]  s;
         logic [31:0] a;
         logic [31:0] b;
         s = 4'($urandom_range(15));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(7))
            0: b = '0;
            1: b = '1;
            2: begin a = MINV; b = '1; end
            3: b = 32'($urandom_range(40));
            default: ;
         endcase
         run_op($sformatf("rand%0d sel%0h", n, s), s, a, b,
                model(s, a, b), model_lat(s, a, b),
                (s >= 4'd12) && (b == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
